uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the team's uart_tx. It deserialises 8N1 frames (LSB first) from the rx pin and presents each completed byte on a held-valid/ack interface to the core. It uses the same programmable bit-period scheme as uart_tx: `set` loads `data[15:0]` as cycles_per_bit, and one bit lasts cycles_per_bit+1 clocks. It flags framing errors and overruns.

Parameters:
UART_SPEED_DEFAULT, 16'h186a, cycles_per_bit value loaded at reset (bit period = value+1 clocks)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
data  input  16  new cycles_per_bit value, sampled when set=1
set  input  1  load cycles_per_bit from data; aborts any frame in progress
rx  input  1  asynchronous serial line, idle high
ack  input  1  consumer acknowledge; clears valid and overrun
rx_data  output  8  last correctly framed byte
valid  output  1  rx_data holds an unacknowledged byte
overrun  output  1  a byte completed while valid was already 1
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, highest priority):
  - rx_data=0, valid=0, overrun=0, frame_err=0, busy=0.
  - cycles_per_bit=UART_SPEED_DEFAULT, FSM=IDLE, counters=0.
  - Both synchroniser flops =1.
- Input sync: rx passes through a 2-flop synchroniser; rx_s is the second flop. The FSM uses only rx_s.
- set (priority below reset):
  - cycles_per_bit<=data, FSM<=IDLE, counter<=0, shift reg unchanged.
  - rx_data, valid and overrun are unaffected.
  - The ack processing rules still apply in that cycle.
- Divisor: values below 4 are loaded as-is; correct reception is not guaranteed for them.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A 16-bit counter runs in START, DATA and STOP. bit_cnt is 3 bits.
  - IDLE: when rx_s==0, go to START with counter=0.
  - START: when counter==(cycles_per_bit>>1):
    - rx_s==0: go to DATA, counter=0, bit_cnt=0.
    - rx_s==1: glitch; go to IDLE with no flags raised.
    - Otherwise counter++.
  - DATA: when counter==cycles_per_bit:
    - Capture rx_s into shift[bit_cnt] (LSB first) and set counter=0.
    - If bit_cnt==7, go to STOP; else bit_cnt++.
    - Otherwise counter++.
  - STOP: when counter==cycles_per_bit:
    - rx_s==1: rx_data<=shift, valid<=1, overrun<=valid_before_update; go to IDLE.
    - rx_s==0: frame_err=1 for exactly this cycle; rx_data and valid unchanged; go to WAIT_HIGH.
    - Otherwise counter++.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. A line held low never causes repeated frame_err.
- Samples land mid-bit: each bit is sampled about (cycles_per_bit>>1)+1 clocks after its nominal edge, plus 2 clocks of synchroniser delay.
- busy=1 in every state except IDLE. It is registered together with the state.
- ack handling:
  - valid=1 and ack=1 with no completion in that cycle: valid<=0, overrun<=0.
  - ack while valid=0 has no effect.
  - Completion and ack in the same cycle: the new byte wins. rx_data updates, valid stays 1, overrun<=0 (the old byte was consumed).
  - Completion while valid=1 and ack=0: rx_data is overwritten, valid stays 1, overrun<=1. overrun stays 1 until ack.
- Back-to-back frames: a start bit beginning right after the stop-bit sample is accepted; IDLE sees rx_s low on the following cycle.
- Reset or set mid-frame: the partial byte is discarded and no flags are raised.

Test Plan:
- Reset then idle line: rx=1 for 1000 clocks -> valid=0, busy=0, frame_err never 1, rx_data=0x00.
- set=1 with data=15 (16 clk/bit), then send 8N1 0xA5 starting at t0 -> busy=1 from about t0+3; valid rises once between t0+150 and t0+156; rx_data=0xA5; overrun=0. Pulse ack -> valid=0 next cycle.
- Divisor 15, send 0x3C and 0xFF back-to-back with no ack -> after the 2nd frame rx_data=0xFF, valid=1, overrun=1. Pulse ack -> valid=0, overrun=0.
- Divisor 15, send 0x81 with the stop bit driven 0, then hold rx low 100 clocks, then high -> frame_err pulses exactly once for 1 clock; valid stays 0; busy stays 1 until rx returns high; a following 0x42 frame is received correctly.
- Divisor 15, drive a 5-clock low glitch on an idle line -> FSM returns to IDLE; no valid, no frame_err; a subsequent 0x55 frame is received correctly.
- Mid-frame abort: reset=1 for 1 clock after 4 data bits -> all outputs at reset values and divisor back to 0x186a. Repeat with set=1 mid-frame -> no valid, prior rx_data kept, and the next frame at the new divisor is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART 8N1 receiver with a programmable bit period, a held-valid/ack byte interface,
// an overrun flag and a one-cycle framing-error pulse.
module uart_rx #(
   parameter logic [15:0] UART_SPEED_DEFAULT = 16'h186a
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data,
   input  logic        set,
   input  logic        rx,
   input  logic        ack,
   output logic [7:0]  rx_data,
   output logic        valid,
   output logic        overrun,
   output logic        frame_err,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t      state, state_n;
   logic [15:0] cycles_per_bit;
   logic [15:0] counter, counter_n;
   logic [2:0]  bit_cnt, bit_cnt_n;
   logic [7:0]  shift, shift_n;
   logic        rx_meta, rx_s;
   logic        complete, stop_fail;
   logic [7:0]  rx_data_n;
   logic        valid_n, overrun_n;

   // The line idles high, so the synchroniser also resets high to avoid a false start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_comb begin
      state_n   = state;
      counter_n = counter;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      complete  = 1'b0;
      stop_fail = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n   = START;
               counter_n = 16'd0;
            end
         end
         START: begin
            if (counter == (cycles_per_bit >> 1)) begin
               counter_n = 16'd0;
               bit_cnt_n = 3'd0;
               state_n   = rx_s ? IDLE : DATA;
            end else begin
               counter_n = counter + 16'd1;
            end
         end
         DATA: begin
            if (counter == cycles_per_bit) begin
               shift_n[bit_cnt] = rx_s;
               counter_n        = 16'd0;
               if (bit_cnt == 3'd7) begin
                  state_n = STOP;
               end else begin
                  bit_cnt_n = bit_cnt + 3'd1;
               end
            end else begin
               counter_n = counter + 16'd1;
            end
         end
         STOP: begin
            if (counter == cycles_per_bit) begin
               counter_n = 16'd0;
               if (rx_s) begin
                  complete = 1'b1;
                  state_n  = IDLE;
               end else begin
                  stop_fail = 1'b1;
                  state_n   = WAIT_HIGH;
               end
            end else begin
               counter_n = counter + 16'd1;
            end
         end
         WAIT_HIGH: begin
            if (rx_s) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n   = IDLE;
            counter_n = 16'd0;
         end
      endcase

      // A divisor load abandons whatever frame was in flight without reporting it.
      if (set) begin
         state_n   = IDLE;
         counter_n = 16'd0;
         complete  = 1'b0;
         stop_fail = 1'b0;
      end
   end

   // A completing byte beats a simultaneous ack; the ack only decides whether it overran.
   always_comb begin
      rx_data_n = rx_data;
      valid_n   = valid;
      overrun_n = overrun;
      if (complete) begin
         rx_data_n = shift_n;
         valid_n   = 1'b1;
         overrun_n = valid && !ack;
      end else if (valid && ack) begin
         valid_n   = 1'b0;
         overrun_n = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cycles_per_bit <= UART_SPEED_DEFAULT;
         counter        <= 16'd0;
         bit_cnt        <= 3'd0;
         shift          <= 8'd0;
         rx_data        <= 8'd0;
         valid          <= 1'b0;
         overrun        <= 1'b0;
         frame_err      <= 1'b0;
         busy           <= 1'b0;
      end else begin
         if (set) begin
            cycles_per_bit <= data;
         end
         state     <= state_n;
         counter   <= counter_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         rx_data   <= rx_data_n;
         valid     <= valid_n;
         overrun   <= overrun_n;
         frame_err <= stop_fail;
         busy      <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are serialised at the bit level, expected bytes
// go into a scoreboard queue, and a negedge monitor pops and compares every delivery.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        reset, set, rx, ack;
   logic [15:0] data;
   logic [7:0]  rx_data;
   logic        valid, overrun, frame_err, busy;

   always #5 clk = ~clk;

   uart_rx dut (
      .clk       (clk),
      .reset     (reset),
      .data      (data),
      .set       (set),
      .rx        (rx),
      .ack       (ack),
      .rx_data   (rx_data),
      .valid     (valid),
      .overrun   (overrun),
      .frame_err (frame_err),
      .busy      (busy)
   );

   typedef struct packed {
      logic [7:0] b;
      logic       ovr;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   int          t0 = 0;
   int          last_event_cycle = 0;
   int          ferr_count = 0;
   int          cur_cpb = 16'h186a;
   logic        model_valid = 1'b0;
   logic [7:0]  last_byte = 8'h00;
   logic        prev_valid = 1'b0;
   logic        prev_ovr = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   int          d, g0, n;
   logic [7:0]  b;
   bit          hold;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick(input int cnt);
      repeat (cnt) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives the first cnt bits of a 10-bit frame (start, data LSB first, stop).
   task automatic driveBits(input logic [9:0] frame, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         rx = frame[i];
         if (i == 0) t0 = cycle;
         tick(cur_cpb + 1);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] byte_in, input logic stop_ok);
      if (stop_ok) begin
         exp_q.push_back('{b: byte_in, ovr: model_valid});
         model_valid = 1'b1;
         last_byte   = byte_in;
      end
      driveBits({stop_ok, byte_in, 1'b0}, 10);
   endtask

   task automatic ackPulse();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      model_valid = 1'b0;
   endtask

   task automatic setDivisor(input logic [15:0] div);
      data = div;
      set  = 1'b1;
      tick(1);
      set  = 1'b0;
      cur_cpb = div;
   endtask

   // Monitor: a delivery is a fresh valid, or new data/overrun appearing while valid is held.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (frame_err === 1'b1) ferr_count++;
         if (valid === 1'b1 && (prev_valid !== 1'b1 || rx_data !== prev_data ||
                                (overrun === 1'b1 && prev_ovr !== 1'b1))) begin
            last_event_cycle = cycle;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_byte: got 0x%02h, expected no delivery", rx_data);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("sb_rx_data", {24'd0, rx_data}, {24'd0, mon_e.b});
               checkOutput("sb_overrun", {31'd0, overrun}, {31'd0, mon_e.ovr});
            end
         end
      end
      prev_valid = valid;
      prev_data  = rx_data;
      prev_ovr   = overrun;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      set   = 1'b0;
      ack   = 1'b0;
      rx    = 1'b1;
      data  = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
      checkOutput("reset_valid", {31'd0, valid}, 32'd0);
      checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
      checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);

      tick(1000);
      checkOutput("idle_valid", {31'd0, valid}, 32'd0);
      checkOutput("idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("idle_frame_err_count", ferr_count, 32'd0);
      checkOutput("idle_rx_data", {24'd0, rx_data}, 32'd0);

      $display("[TB] single frame 0xA5 at divisor 15");
      setDivisor(16'd15);
      applyStimulus(8'hA5, 1'b1);
      d = last_event_cycle - t0;
      checkOutput("a5_latency_window", {31'd0, (d >= 150 && d <= 156)}, 32'd1);
      checkOutput("a5_valid", {31'd0, valid}, 32'd1);
      checkOutput("a5_overrun", {31'd0, overrun}, 32'd0);
      checkOutput("a5_busy_after", {31'd0, busy}, 32'd0);
      ackPulse();
      checkOutput("a5_ack_valid", {31'd0, valid}, 32'd0);

      $display("[TB] back-to-back 0x3C, 0xFF without ack");
      applyStimulus(8'h3C, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      checkOutput("b2b_rx_data", {24'd0, rx_data}, 32'hFF);
      checkOutput("b2b_valid", {31'd0, valid}, 32'd1);
      checkOutput("b2b_overrun", {31'd0, overrun}, 32'd1);
      ackPulse();
      checkOutput("b2b_ack_valid", {31'd0, valid}, 32'd0);
      checkOutput("b2b_ack_overrun", {31'd0, overrun}, 32'd0);

      $display("[TB] framing error on 0x81");
      applyStimulus(8'h81, 1'b0);
      tick(100);
      checkOutput("ferr_busy_low_line", {31'd0, busy}, 32'd1);
      checkOutput("ferr_count_once", ferr_count, 32'd1);
      checkOutput("ferr_valid", {31'd0, valid}, 32'd0);
      rx = 1'b1;
      tick(5);
      checkOutput("ferr_busy_released", {31'd0, busy}, 32'd0);
      applyStimulus(8'h42, 1'b1);
      checkOutput("ferr_next_valid", {31'd0, valid}, 32'd1);
      ackPulse();

      $display("[TB] start-bit glitch");
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(30);
      checkOutput("glitch_busy", {31'd0, busy}, 32'd0);
      checkOutput("glitch_valid", {31'd0, valid}, 32'd0);
      checkOutput("glitch_ferr_count", ferr_count, 32'd1);
      applyStimulus(8'h55, 1'b1);
      ackPulse();

      $display("[TB] randomized frames");
      for (int r = 0; r < 2; r++) begin
         setDivisor((r == 0) ? 16'd9 : 16'd20);
         for (int k = 0; k < 8; k++) begin
            b    = 8'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            if (model_valid && b == last_byte) b = b ^ 8'h01;
            applyStimulus(b, 1'b1);
            tick($urandom_range(0, 2));
            if (!hold) begin
               ackPulse();
               checkOutput("rand_ack_valid", {31'd0, valid}, 32'd0);
            end
         end
         if (model_valid) ackPulse();
      end

      $display("[TB] reset mid-frame");
      setDivisor(16'd15);
      driveBits({1'b1, 8'h5A, 1'b0}, 5);
      reset = 1'b1;
      rx    = 1'b1;
      tick(1);
      reset = 1'b0;
      cur_cpb = 16'h186a;
      checkOutput("midreset_rx_data", {24'd0, rx_data}, 32'd0);
      checkOutput("midreset_valid", {31'd0, valid}, 32'd0);
      checkOutput("midreset_overrun", {31'd0, overrun}, 32'd0);
      checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
      checkOutput("midreset_frame_err", {31'd0, frame_err}, 32'd0);

      // A short low pulse keeps START busy for half the default bit period.
      rx = 1'b0;
      g0 = cycle;
      tick(5);
      rx = 1'b1;
      tick(95);
      checkOutput("default_div_busy_early", {31'd0, busy}, 32'd1);
      n = 0;
      while (busy === 1'b1 && n < 4000) begin
         tick(1);
         n++;
      end
      d = cycle - g0;
      checkOutput("default_div_busy_cleared", {31'd0, busy}, 32'd0);
      checkOutput("default_div_half_period", {31'd0, (d >= 3120 && d <= 3140)}, 32'd1);

      $display("[TB] set mid-frame");
      setDivisor(16'd15);
      applyStimulus(8'h99, 1'b1);
      ackPulse();
      driveBits({1'b1, 8'h77, 1'b0}, 5);
      data = 16'd11;
      set  = 1'b1;
      rx   = 1'b1;
      tick(1);
      set  = 1'b0;
      cur_cpb = 11;
      tick(36);
      checkOutput("midset_valid", {31'd0, valid}, 32'd0);
      checkOutput("midset_rx_data_kept", {24'd0, rx_data}, 32'h99);
      checkOutput("midset_busy", {31'd0, busy}, 32'd0);
      checkOutput("midset_ferr_count", ferr_count, 32'd1);
      applyStimulus(8'h6E, 1'b1);
      checkOutput("midset_next_valid", {31'd0, valid}, 32'd1);
      checkOutput("midset_next_rx_data", {24'd0, rx_data}, 32'h6E);
      ackPulse();

      tick(20);
      checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
      checkOutput("frame_err_total", ferr_count, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
